// File: rtl/meyesight_fabric_top.sv
// Fabric-side sensor scanner: row/column sweep, 16-bit SPI ADC capture, PSRAM pixel writes, frame LEDs.
// Build option TEST_PATTERN_EN: write the pixel index instead of the ADC sample.
`timescale 1ns/1ps
module meyesight_fabric_top #(
    parameter int unsigned ROWS      = 112,
    parameter int unsigned COLS      = 112,
    parameter int unsigned SCLK_DIV  = 2,
    parameter int unsigned SETTLE    = 8,
    parameter int unsigned WR_CYCLES = 4,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        CLK50,
    input  logic        MSS_RESET,
    input  logic        MISO,
    output logic        CS,
    output logic        SCLK,
    output logic        resp,
    output logic        incp,
    output logic        resv,
    output logic        incv,
    output logic        inphi,
    output logic [24:0] psram_address,
    inout  wire  [15:0] psram_data,
    output logic [1:0]  psram_nbyte_en,
    output logic        psram_ncs0,
    output logic        psram_ncs1,
    output logic        psram_nwe,
    output logic        psram_noe0,
    output logic        psram_noe1,
    output logic [7:0]  led
);

    typedef enum logic [2:0] {FRAME, ROW, PHI, ADC, WR, INCV, INCP} state_t;

    state_t      state;
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] cnt;
    logic [15:0] div;
    logic [5:0]  half;
    logic [11:0] shreg;
    logic [15:0] wdata;
    logic [24:0] pix_idx;

    assign pix_idx    = 25'(row) * 25'(COLS) + 25'(col);
    assign psram_data = psram_ncs0 ? 'z : wdata;
    assign psram_ncs1 = 1'b1;
    assign psram_noe0 = 1'b1;
    assign psram_noe1 = 1'b1;

    // Outputs are registered on the edge that enters each phase, so the
    // state name always matches what is visible on the pins.
    always_ff @(posedge CLK50 or posedge MSS_RESET) begin
        if (MSS_RESET) begin
            state          <= FRAME;
            row            <= '0;
            col            <= '0;
            cnt            <= '0;
            div            <= '0;
            half           <= '0;
            shreg          <= '0;
            wdata          <= '0;
            CS             <= 1'b1;
            SCLK           <= 1'b1;
            resp           <= 1'b0;
            incp           <= 1'b0;
            resv           <= 1'b0;
            incv           <= 1'b0;
            inphi          <= 1'b0;
            psram_address  <= '0;
            psram_nbyte_en <= 2'b11;
            psram_ncs0     <= 1'b1;
            psram_nwe      <= 1'b1;
            led            <= '0;
        end else begin
            case (state)
                FRAME: begin
                    row <= '0;
                    if (!resp) begin
                        resp <= 1'b1;
                    end else begin
                        resp  <= 1'b0;
                        resv  <= 1'b1;
                        col   <= '0;
                        state <= ROW;
                    end
                end
                ROW: begin
                    resv  <= 1'b0;
                    inphi <= 1'b1;
                    cnt   <= '0;
                    state <= PHI;
                end
                PHI: begin
                    if (cnt == 16'(SETTLE - 1)) begin
                        CS    <= 1'b0;
                        div   <= '0;
                        half  <= '0;
                        state <= ADC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ADC: begin
                    if (half == 6'd32) begin
                        CS             <= 1'b1;
                        inphi          <= 1'b0;
                        psram_ncs0     <= 1'b0;
                        psram_nbyte_en <= 2'b00;
                        psram_address  <= 25'(BASE_ADDR) + pix_idx;
`ifdef TEST_PATTERN_EN
                        wdata          <= {4'b0, pix_idx[11:0]};
`else
                        wdata          <= {4'b0, shreg};
`endif
                        cnt            <= '0;
                        state          <= WR;
                    end else if (div == 16'(SCLK_DIV - 1)) begin
                        div  <= '0;
                        SCLK <= ~SCLK;
                        half <= half + 6'd1;
                        // A 12-bit window naturally drops the four leading zeros.
                        if (!SCLK)
                            shreg <= {shreg[10:0], MISO};
                    end else begin
                        div <= div + 16'd1;
                    end
                end
                WR: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'd0)
                        psram_nwe <= 1'b0;
                    if (cnt == 16'(WR_CYCLES))
                        psram_nwe <= 1'b1;
                    if (cnt == 16'(WR_CYCLES + 1)) begin
                        psram_ncs0     <= 1'b1;
                        psram_nbyte_en <= 2'b11;
                        incv           <= 1'b1;
                        state          <= INCV;
                    end
                end
                INCV: begin
                    incv <= 1'b0;
                    if (col < 16'(COLS - 1)) begin
                        col   <= col + 16'd1;
                        inphi <= 1'b1;
                        cnt   <= '0;
                        state <= PHI;
                    end else begin
                        incp  <= 1'b1;
                        state <= INCP;
                    end
                end
                INCP: begin
                    incp <= 1'b0;
                    if (row < 16'(ROWS - 1)) begin
                        row   <= row + 16'd1;
                        col   <= '0;
                        resv  <= 1'b1;
                        state <= ROW;
                    end else begin
                        led   <= {led[7:1] + 7'd1, ~led[0]};
                        row   <= '0;
                        state <= FRAME;
                    end
                end
                default: state <= FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_meyesight_fabric_top.sv
// Bench for meyesight_fabric_top: table-driven pixel writes with a scoreboard, PSRAM/ADC timing monitor,
// frame LEDs, mid-conversion reset, and 25-bit address wrap on a second instance.
`timescale 1ns/1ps
module tb_meyesight_fabric_top;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst = 1'b1;
    logic miso_a = 1'b0;
    logic miso_b = 1'b0;

    logic        cs_a, sclk_a, resp_a, incp_a, resv_a, incv_a, inphi_a;
    logic [24:0] addr_a;
    wire  [15:0] data_a;
    logic [1:0]  nbe_a;
    logic        ncs0_a, ncs1_a, nwe_a, noe0_a, noe1_a;
    logic [7:0]  led_a;

    logic        cs_b, sclk_b, resp_b, incp_b, resv_b, incv_b, inphi_b;
    logic [24:0] addr_b;
    wire  [15:0] data_b;
    logic [1:0]  nbe_b;
    logic        ncs0_b, ncs1_b, nwe_b, noe0_b, noe1_b;
    logic [7:0]  led_b;

    meyesight_fabric_top #(.ROWS(2), .COLS(3), .SCLK_DIV(2), .SETTLE(8), .WR_CYCLES(4), .BASE_ADDR(0)) dut_a (
        .CLK50(clk), .MSS_RESET(rst), .MISO(miso_a), .CS(cs_a), .SCLK(sclk_a),
        .resp(resp_a), .incp(incp_a), .resv(resv_a), .incv(incv_a), .inphi(inphi_a),
        .psram_address(addr_a), .psram_data(data_a), .psram_nbyte_en(nbe_a),
        .psram_ncs0(ncs0_a), .psram_ncs1(ncs1_a), .psram_nwe(nwe_a),
        .psram_noe0(noe0_a), .psram_noe1(noe1_a), .led(led_a)
    );

    meyesight_fabric_top #(.ROWS(1), .COLS(4), .SCLK_DIV(2), .SETTLE(8), .WR_CYCLES(4), .BASE_ADDR(32'h1FFFFFE)) dut_b (
        .CLK50(clk), .MSS_RESET(rst), .MISO(miso_b), .CS(cs_b), .SCLK(sclk_b),
        .resp(resp_b), .incp(incp_b), .resv(resv_b), .incv(incv_b), .inphi(inphi_b),
        .psram_address(addr_b), .psram_data(data_b), .psram_nbyte_en(nbe_b),
        .psram_ncs0(ncs0_b), .psram_ncs1(ncs1_b), .psram_nwe(nwe_b),
        .psram_noe0(noe0_b), .psram_noe1(noe1_b), .led(led_b)
    );

    typedef struct {
        logic [11:0] sample;
        logic [24:0] addr;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] data;
    } exp_t;

    vec_t tbl [6];
    exp_t sb [$];

    int checks = 0;
    int failures = 0;
    int viol = 0;
    int resp_n = 0, resv_n = 0, incv_n = 0, incp_n = 0;
    int b_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC model for instance A: word chosen from the table, MSB first on SCLK falling edges.
    initial begin : adc_a
        int pix;
        int bitn;
        logic [15:0] word;
        pix = 0;
        bitn = 15;
        word = '0;
        forever begin
            @(negedge cs_a or negedge sclk_a or posedge rst);
            if (rst) begin
                pix = 0;
                sb.delete();
                miso_a = 1'b0;
            end else if (sclk_a) begin
`ifdef TEST_PATTERN_EN
                word = 16'hFFFF;
`else
                word = {4'hF, tbl[pix].sample};
`endif
                sb.push_back('{tbl[pix].addr, tbl[pix].data});
                pix = (pix + 1) % 6;
                bitn = 15;
            end else if (bitn >= 0) begin
                miso_a = word[bitn];
                bitn--;
            end
        end
    end

    initial begin : adc_b
        int bitn;
        logic [15:0] word;
        bitn = 15;
`ifdef TEST_PATTERN_EN
        word = 16'hFFFF;
`else
        word = 16'hFABC;
`endif
        forever begin
            @(negedge cs_b or negedge sclk_b or posedge rst);
            if (rst) begin
                miso_b = 1'b0;
            end else if (sclk_b) begin
                bitn = 15;
            end else if (bitn >= 0) begin
                miso_b = word[bitn];
                bitn--;
            end
        end
    end

    // Protocol monitor for instance A, sampled on the falling clock edge.
    initial begin : mon_a
        logic p_cs, p_sclk, p_nwe, p_ncs0, p_inphi;
        logic [3:0] p_str, str;
        int cs_len, sc_rises, nwe_len, ncs0_len, inphi_len;
        p_cs = 1; p_sclk = 1; p_nwe = 1; p_ncs0 = 1; p_inphi = 0; p_str = '0;
        cs_len = 0; sc_rises = 0; nwe_len = 0; ncs0_len = 0; inphi_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_cs = 1; p_sclk = 1; p_nwe = 1; p_ncs0 = 1; p_inphi = 0; p_str = '0;
                cs_len = 0; sc_rises = 0; nwe_len = 0; ncs0_len = 0; inphi_len = 0;
                resp_n = 0; resv_n = 0; incv_n = 0; incp_n = 0;
            end else begin
                str = {resp_a, resv_a, incv_a, incp_a};
                if ($countones(str) > 1) begin
                    viol++;
                    $display("FAIL strobe_overlap: got %b at %0t", str, $time);
                end
                if ((str & p_str) != 4'b0) begin
                    viol++;
                    $display("FAIL strobe_width: got %b after %b at %0t", str, p_str, $time);
                end
                if (!noe0_a || !noe1_a || !ncs1_a) begin
                    viol++;
                    $display("FAIL idle_selects: noe0=%b noe1=%b ncs1=%b at %0t", noe0_a, noe1_a, ncs1_a, $time);
                end
                if ((ncs0_a && nbe_a != 2'b11) || (!ncs0_a && nbe_a != 2'b00)) begin
                    viol++;
                    $display("FAIL byte_enables: got %b with ncs0=%b at %0t", nbe_a, ncs0_a, $time);
                end
                if (!p_cs && cs_a) begin
                    check("cs_low_clks", cs_len, 65);
                    check("sclk_rises", sc_rises, 16);
                    check("sclk_idle_high", sclk_a, 1);
                    check("inphi_drop_with_cs", inphi_a, 0);
                    sc_rises = 0;
                end
                if (!cs_a && !p_sclk && sclk_a) sc_rises++;
                if (p_nwe && !nwe_a) check("ncs0_setup_clks", ncs0_len, 1);
                if (!p_nwe && nwe_a) check("nwe_low_clks", nwe_len, 4);
                if (!p_ncs0 && ncs0_a) check("ncs0_low_clks", ncs0_len, 6);
                if (p_inphi && !inphi_a) check("inphi_high_clks", inphi_len, 73);
                if (resp_a && !p_str[3]) resp_n++;
                if (resv_a && !p_str[2]) resv_n++;
                if (incv_a && !p_str[1]) incv_n++;
                if (incp_a && !p_str[0]) incp_n++;
                cs_len    = cs_a    ? 0 : cs_len + 1;
                nwe_len   = nwe_a   ? 0 : nwe_len + 1;
                ncs0_len  = ncs0_a  ? 0 : ncs0_len + 1;
                inphi_len = inphi_a ? inphi_len + 1 : 0;
                p_cs = cs_a; p_sclk = sclk_a; p_nwe = nwe_a; p_ncs0 = ncs0_a; p_inphi = inphi_a; p_str = str;
            end
        end
    end

    // Instance B starts two words below the top of the address space and must wrap.
    initial begin : mon_b
        logic p_nwe;
        logic [24:0] b_addr [4];
        logic [15:0] exp_d;
        b_addr[0] = 25'h1FFFFFE;
        b_addr[1] = 25'h1FFFFFF;
        b_addr[2] = 25'h0000000;
        b_addr[3] = 25'h0000001;
        p_nwe = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && p_nwe && !nwe_b && b_n < 4) begin
`ifdef TEST_PATTERN_EN
                exp_d = 16'(b_n);
`else
                exp_d = 16'h0ABC;
`endif
                check("wrap_addr", addr_b, b_addr[b_n]);
                check("wrap_data", data_b, exp_d);
                b_n++;
            end
            p_nwe = rst ? 1'b1 : nwe_b;
        end
    end

    task automatic wait_write(output bit ok);
        logic p;
        p = nwe_a;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (p && !nwe_a) begin
                ok = 1'b1;
                break;
            end
            p = nwe_a;
        end
    endtask

    task automatic check_write(input string name, input int k);
        bit ok;
        exp_t e;
        wait_write(ok);
        if (!ok) begin
            check({name, "_timeout"}, 0, 1);
        end else if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({name, "_addr"}, addr_a, tbl[k].addr);
            check({name, "_data"}, data_a, e.data);
            check({name, "_ncs0"}, ncs0_a, 0);
        end
    endtask

    initial begin : main
        logic [11:0] samples [6];
        logic [7:0]  led_exp [3];
        logic [7:0]  p_led;
        bit          seen;

        samples[0] = 12'hABC; samples[1] = 12'h001; samples[2] = 12'h800;
        samples[3] = 12'hFFF; samples[4] = 12'h555; samples[5] = 12'h2A7;
        for (int k = 0; k < 6; k++) begin
            tbl[k].sample = samples[k];
            tbl[k].addr   = 25'(k);
`ifdef TEST_PATTERN_EN
            tbl[k].data   = 16'(k);
`else
            tbl[k].data   = {4'h0, samples[k]};
`endif
        end
        led_exp[0] = 8'h03; led_exp[1] = 8'h04; led_exp[2] = 8'h07;

        repeat (3) @(negedge clk);
        check("rst_cs", cs_a, 1);
        check("rst_sclk", sclk_a, 1);
        check("rst_strobes", {resp_a, resv_a, incv_a, incp_a, inphi_a}, 5'b0);
        check("rst_psram_ctl", {ncs0_a, nwe_a, nbe_a}, 4'b1111);
        check("rst_addr", addr_a, 0);
        check("rst_led", led_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("resp_after_release", resp_a, 1);

        for (int k = 0; k < 6; k++)
            check_write("pix", k);

        for (int f = 0; f < 3; f++) begin
            p_led = led_a;
            seen = 1'b0;
            for (int i = 0; i < 700; i++) begin
                @(negedge clk);
                if (led_a != p_led) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("led_change_seen", seen, 1);
            if (f == 0) begin
                check("frame_resp", resp_n, 1);
                check("frame_resv", resv_n, 2);
                check("frame_incv", incv_n, 6);
                check("frame_incp", incp_n, 2);
            end
            check("led_frame", led_a, led_exp[f]);
        end

        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cs_a) begin
                seen = 1'b1;
                break;
            end
        end
        check("adc_active_seen", seen, 1);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs", cs_a, 1);
        check("midrst_sclk", sclk_a, 1);
        check("midrst_strobes", {resp_a, resv_a, incv_a, incp_a, inphi_a}, 5'b0);
        check("midrst_psram_ctl", {ncs0_a, nwe_a, nbe_a}, 4'b1111);
        check("midrst_led", led_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_resp", resp_a, 1);
        @(negedge clk);
        check("midrst_resv", {resp_a, resv_a}, 2'b01);
        check_write("restart", 0);

        check("protocol_violations", viol, 0);
        check("wrap_writes_seen", b_n >= 4, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/meyesight_fabric_top.md
Name: meyesight_fabric_top

Overview:
- Fabric-side top of the vision board: scans a ROWS×COLS analog image sensor and digitises each pixel through an external 12-bit SPI ADC.
- Each sample is written to external 16-bit PSRAM and frame progress is shown on LEDs.
- MSS processor, Ethernet MAC, UART and RS-485 are outside this block.
- The MSS reads frames from PSRAM after a frame completes, as indicated by led[0] toggling.

Parameters:
ROWS, 112, sensor rows scanned per frame
COLS, 112, sensor columns scanned per row
SCLK_DIV, 2, CLK50 cycles per SCLK half-period (≥1)
SETTLE, 8, CLK50 cycles inphi held high before conversion
WR_CYCLES, 4, CLK50 cycles psram_nwe held low per write
BASE_ADDR, 0, 25-bit PSRAM word address of pixel (0,0)

Ports:
CLK50  in  1  system clock, 50 MHz, all logic on rising edge
MSS_RESET  in  1  asynchronous active-high reset
MISO  in  1  ADC serial data
CS  out  1  ADC chip select, active low
SCLK  out  1  ADC serial clock
resp  out  1  sensor pointer-register reset pulse
incp  out  1  sensor pointer increment (next row)
resv  out  1  sensor value-register reset pulse
incv  out  1  sensor value increment (next column)
inphi  out  1  sensor amplifier enable
psram_address  out  25  PSRAM word address
psram_data  inout  16  PSRAM data bus
psram_nbyte_en  out  2  byte enables, active low
psram_ncs0  out  1  PSRAM chip select 0, active low
psram_ncs1  out  1  chip select 1, held high
psram_nwe  out  1  write enable, active low
psram_noe0  out  1  output enable 0, held high
psram_noe1  out  1  output enable 1, held high
led  out  8  status LEDs

Behaviour:
- Reset values:
  - CS=1, SCLK=1.
  - resp/incp/resv/incv/inphi=0.
  - psram_ncs0/ncs1/nwe/noe0/noe1=1, psram_nbyte_en=2'b11, psram_address=0, psram_data tri-stated.
  - led=0.
  - FSM in FRAME state, row=col=0.
- FSM (free-running after reset):
  - FRAME: resp=1 for 1 clk; row=0 → ROW.
  - ROW: resv=1 for 1 clk; col=0 → PHI.
  - PHI: inphi=1 for SETTLE clks → ADC.
  - ADC: CS=0 for 16 SCLK periods.
    - SCLK toggles every SCLK_DIV clks, first edge falling.
    - MISO sampled on each SCLK rising edge, MSB first.
    - After the 16th rising edge: SCLK=1, then CS=1 one clk later.
    - Sample = last 12 bits received; first 4 bits are leading zeros and are discarded.
    - inphi stays 1 through ADC; drops when CS rises.
  - WR:
    - address = BASE_ADDR + row*COLS + col; data = {4'b0, sample}; nbyte_en=2'b00; ncs0=0.
    - nwe=0 for WR_CYCLES clks; address, data and ncs0 stable one clk before nwe falls and one clk after it rises.
    - Data bus driven only while ncs0=0.
  - INCV: incv=1 for 1 clk.
    - If col<COLS-1: col++, → PHI.
    - Else → INCP.
  - INCP: incp=1 for 1 clk.
    - If row<ROWS-1: row++, → ROW.
    - Else: led[0] toggles, led[7:1] increments (wraps 127→0), → FRAME.
- Sensor strobes are 1-clk pulses and never overlap.
- Per-pixel time: SETTLE + 32*SCLK_DIV + 1 + WR_CYCLES + 2 + 1 clks. With defaults: 8+64+1+4+2+1 = 80 clks.
- Reset mid-frame aborts immediately to reset values; the next frame restarts at row 0 col 0. The partially written frame is not cleaned.
- psram_address arithmetic is 25-bit and wraps modulo 2^25.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined:
  - ADC transfer still runs with full CS/SCLK timing.
  - Written data = (row*COLS+col) & 12'hFFF instead of the sample, for PSRAM path checking.
- Undefined: the ADC sample is written.

Test Plan:
- Reset: assert MSS_RESET mid-ADC → CS=1, SCLK=1, all strobes 0, psram_ncs0=1, nwe=1, data Z, led=0 within same cycle; release → resp pulse 1 clk later.
- ADC capture: ROWS=1, COLS=1, MISO model returns 16'h0ABC → PSRAM write to address BASE_ADDR with data 16'h0ABC; exactly 16 SCLK rising edges while CS=0.
- Scan order: ROWS=2, COLS=3, MISO model returns pixel index → writes at addresses 0..5, data 0..5 in order; 3 incv per row, 2 incp, 1 resp and 2 resv per frame.
- PSRAM timing: check nwe low exactly WR_CYCLES=4 clks, ncs0 low 6 clks, noe0/noe1/ncs1 never low, nbyte_en=00 only during write.
- Frame LED: ROWS=2, COLS=2, run 3 frames → led[0] = 1,0,1 after each; led[7:1] = 1,2,3.
- TEST_PATTERN_EN defined, MISO=1 constantly → data written equals address offset (0,1,2,…), not 12'hFFF.
